// File: rtl/bus_read_sequencer.sv
// Sequences reads from four tri-state bus drivers: enable one driver, let the bus settle, capture, hold for the consumer.
// Optional macro BRS_PARITY_EN widens BUS to 9 bits (odd parity in BUS[8]) and adds the PERR output.
module bus_read_sequencer #(
    parameter int SETTLE = 1
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       REQ,
    input  logic [1:0] SEL,
    output logic       RDY,
    output logic [4:1] G,
`ifdef BRS_PARITY_EN
    input  logic [8:0] BUS,
`else
    input  logic [7:0] BUS,
`endif
    output logic [7:0] Q,
    output logic       VALID,
    input  logic       ACK,
`ifdef BRS_PARITY_EN
    output logic       PERR,
`endif
    output logic [1:0] state_dbg
);

    // Handshakes: REQ is taken on an edge where RDY=1; Q is handed over on an edge where VALID=1 and ACK=1.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [1:0] sel_q, sel_next;
    logic [4:1] g_next;
    logic [7:0] q_next;
    logic       perr_q, perr_next;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            sel_q  <= 2'd0;
            G      <= 4'b0000;
            Q      <= 8'h00;
            perr_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            sel_q  <= sel_next;
            G      <= g_next;
            Q      <= q_next;
            perr_q <= perr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sel_next   = sel_q;
        q_next     = Q;
        perr_next  = perr_q;
        case (state)
            IDLE: begin
                if (REQ) begin
                    state_next = DRIVE;
                    sel_next   = SEL;
                    cnt_next   = 4'(SETTLE);
                end
            end
            DRIVE: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = HOLD;
                    q_next     = BUS[7:0];
`ifdef BRS_PARITY_EN
                    perr_next  = ~^BUS;
`endif
                end
            end
            HOLD: begin
                if (ACK) begin
                    state_next = IDLE;
                    perr_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
        // Enables are registered from the next state so G never glitches and is one-hot by construction.
        g_next = (state_next == DRIVE) ? (4'b0001 << sel_next) : 4'b0000;
    end

    assign RDY       = (state == IDLE);
    assign VALID     = (state == HOLD);
    assign state_dbg = state;

`ifdef BRS_PARITY_EN
    assign PERR = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_bus_read_sequencer.sv
// Bench for bus_read_sequencer: SETTLE=1 and SETTLE=3 instances share inputs, each checked against a timestamp model.
// Build with BRS_PARITY_EN defined to also cover the parity variant.
module tb_bus_read_sequencer;

`ifdef BRS_PARITY_EN
    localparam int BW = 9;
`else
    localparam int BW = 8;
`endif

    // ---------------- clock / reset ----------------
    logic          CLK = 1'b0;
    logic          CLR = 1'b1;
    logic          REQ = 1'b0;
    logic [1:0]    SEL = 2'd0;
    logic          ACK = 1'b0;
    logic [BW-1:0] BUS = '0;

    always #5 CLK = ~CLK;

    logic       rdy_o   [2];
    logic [4:1] g_o     [2];
    logic [7:0] q_o     [2];
    logic       valid_o [2];
    logic [1:0] dbg_o   [2];
`ifdef BRS_PARITY_EN
    logic       perr_o  [2];
`endif

    bus_read_sequencer #(.SETTLE(1)) u_dut1 (
        .CLK(CLK), .CLR(CLR), .REQ(REQ), .SEL(SEL), .RDY(rdy_o[0]), .G(g_o[0]),
        .BUS(BUS), .Q(q_o[0]), .VALID(valid_o[0]), .ACK(ACK),
`ifdef BRS_PARITY_EN
        .PERR(perr_o[0]),
`endif
        .state_dbg(dbg_o[0])
    );

    bus_read_sequencer #(.SETTLE(3)) u_dut3 (
        .CLK(CLK), .CLR(CLR), .REQ(REQ), .SEL(SEL), .RDY(rdy_o[1]), .G(g_o[1]),
        .BUS(BUS), .Q(q_o[1]), .VALID(valid_o[1]), .ACK(ACK),
`ifdef BRS_PARITY_EN
        .PERR(perr_o[1]),
`endif
        .state_dbg(dbg_o[1])
    );

    // ---------------- scoreboard / model state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int k     = 0;              // rising edges seen since time zero

    logic [7:0] exp_q1[$];      // captured words awaiting hand-over, SETTLE=1
    logic [7:0] exp_q3[$];      // same, SETTLE=3

    int         acc  [2];       // edge index of the accepting edge, -1 when no read in flight
    logic [1:0] sl   [2];
    logic [7:0] mq   [2];
    logic       mperr[2];
    logic       pend [2];       // a hand-over happened on this edge; Q must equal popped word
    logic [7:0] pval [2];
    int         zrun [2];       // consecutive sampled cycles with G=0
    logic       seen_en[2];
    logic [4:1] prev_g [2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            acc[i] = -1; sl[i] = 2'd0; mq[i] = 8'h00; mperr[i] = 1'b0;
            pend[i] = 1'b0; zrun[i] = 0; seen_en[i] = 1'b0; prev_g[i] = 4'b0000;
        end
        exp_q1.delete();
        exp_q3.delete();
    endtask

    // One rising edge, evaluated in terms of distance from the accepting edge.
    task automatic model_edge(input int i);
        int s;
        s = settle_of(i);
        pend[i] = 1'b0;
        if (acc[i] < 0) begin
            if (REQ) begin
                acc[i] = k;
                sl[i]  = SEL;
            end
        end else if (k == acc[i] + s) begin
            mq[i] = BUS[7:0];
`ifdef BRS_PARITY_EN
            mperr[i] = ($countones(BUS) % 2) == 0;
`endif
            if (i == 0) exp_q1.push_back(BUS[7:0]);
            else        exp_q3.push_back(BUS[7:0]);
        end else if (k > acc[i] + s && ACK) begin
            acc[i]   = -1;
            mperr[i] = 1'b0;
            pend[i]  = 1'b1;
            if (i == 0) pval[i] = exp_q1.pop_front();
            else        pval[i] = exp_q3.pop_front();
        end
    endtask

    task automatic compare(input int i);
        int         s;
        logic       busy, drive, valid;
        logic [4:1] eg;
        s     = settle_of(i);
        busy  = acc[i] >= 0;
        drive = busy && (k < acc[i] + s);
        valid = busy && (k >= acc[i] + s);
        eg    = drive ? (4'b0001 << sl[i]) : 4'b0000;
        check($sformatf("rdy%0d", i),   rdy_o[i],   !busy);
        check($sformatf("valid%0d", i), valid_o[i], valid);
        check($sformatf("g%0d", i),     g_o[i],     eg);
        check($sformatf("q%0d", i),     q_o[i],     mq[i]);
        check($sformatf("onehot%0d", i), ($countones(g_o[i]) <= 1), 1'b1);
        check($sformatf("dbg_idle%0d", i), (dbg_o[i] == 2'd0), !busy);
`ifdef BRS_PARITY_EN
        check($sformatf("perr%0d", i),  perr_o[i],  mperr[i]);
`endif
        if (pend[i])
            check($sformatf("sb_q%0d", i), q_o[i], pval[i]);
        if (g_o[i] != 4'b0000) begin
            if (seen_en[i] && prev_g[i] == 4'b0000)
                check($sformatf("gap%0d", i), (zrun[i] >= 2), 1'b1);
            seen_en[i] = 1'b1;
            zrun[i]    = 0;
        end else begin
            zrun[i]++;
        end
        prev_g[i] = g_o[i];
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic req, input logic [1:0] sel, input logic ack, input logic [BW-1:0] bus);
        @(negedge CLK);
        REQ = req; SEL = sel; ACK = ack; BUS = bus;
        @(posedge CLK);
        k++;
        for (int i = 0; i < 2; i++) model_edge(i);
        #1;
        for (int i = 0; i < 2; i++) compare(i);
    endtask

    // Asynchronous clear in mid-cycle, checked before any clock edge.
    task automatic do_clear();
        #2;
        REQ = 1'b0; ACK = 1'b0;
        CLR = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("clr_g%0d", i),     g_o[i],     4'b0000);
            check($sformatf("clr_q%0d", i),     q_o[i],     8'h00);
            check($sformatf("clr_valid%0d", i), valid_o[i], 1'b0);
            check($sformatf("clr_rdy%0d", i),   rdy_o[i],   1'b1);
`ifdef BRS_PARITY_EN
            check($sformatf("clr_perr%0d", i),  perr_o[i],  1'b0);
`endif
        end
        @(posedge CLK);
        k++;
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    function automatic logic [BW-1:0] rbus();
        return BW'($urandom);
    endfunction

    task automatic drain();
        for (int n = 0; n < 6; n++) step(1'b0, 2'd0, 1'b1, rbus());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_rdy%0d", i),   rdy_o[i],   1'b1);
            check($sformatf("rst_g%0d", i),     g_o[i],     4'b0000);
            check($sformatf("rst_q%0d", i),     q_o[i],     8'h00);
            check($sformatf("rst_valid%0d", i), valid_o[i], 1'b0);
        end
        @(negedge CLK);
        CLR = 1'b0;

        // SETTLE=1 single read, SEL=2, bus A5
        step(1'b1, 2'd2, 1'b0, BW'(8'hA5));
        check("d1_g_accept", g_o[0], 4'b0100);
        step(1'b0, 2'd0, 1'b0, BW'(8'hA5));
        check("d1_g_off", g_o[0], 4'b0000);
        check("d1_valid", valid_o[0], 1'b1);
        check("d1_q", q_o[0], 8'hA5);
        step(1'b0, 2'd0, 1'b1, BW'(8'h00));
        check("d1_valid_ack", valid_o[0], 1'b0);
        check("d1_rdy_ack", rdy_o[0], 1'b1);
        drain();

        // SETTLE=3, SEL=0, bus changes in the last DRIVE cycle
        step(1'b1, 2'd0, 1'b0, BW'(8'h11));
        check("d3_g_c1", g_o[1], 4'b0001);
        step(1'b0, 2'd3, 1'b0, BW'(8'h11));
        check("d3_g_c2", g_o[1], 4'b0001);
        step(1'b0, 2'd3, 1'b0, BW'(8'h11));
        check("d3_g_c3", g_o[1], 4'b0001);
        step(1'b0, 2'd3, 1'b0, BW'(8'h22));
        check("d3_g_end", g_o[1], 4'b0000);
        check("d3_q", q_o[1], 8'h22);
        check("d3_valid", valid_o[1], 1'b1);
        drain();

        // continuous REQ with ACK tied high
        for (int n = 0; n < 40; n++) step(1'b1, 2'($urandom_range(0, 3)), 1'b1, rbus());
        drain();

        // clear during the 2nd DRIVE cycle with Q previously 5A
        step(1'b1, 2'd1, 1'b0, BW'(8'h5A));
        for (int n = 0; n < 3; n++) step(1'b0, 2'd1, 1'b0, BW'(8'h5A));
        check("c_q_before", q_o[1], 8'h5A);
        step(1'b0, 2'd0, 1'b1, BW'(8'h00));
        step(1'b1, 2'd2, 1'b0, BW'(8'h77));
        step(1'b0, 2'd2, 1'b0, BW'(8'h77));
        do_clear();
        for (int n = 0; n < 5; n++) step(1'b0, 2'd0, 1'b0, BW'(8'h77));

        // REQ pulsed during HOLD with ACK held low
        step(1'b1, 2'd1, 1'b0, BW'(8'h3C));
        for (int n = 0; n < 3; n++) step(1'b0, 2'd1, 1'b0, BW'(8'h3C));
        for (int n = 0; n < 10; n++) step(n[0], 2'd3, 1'b0, rbus());
        check("h_valid", valid_o[1], 1'b1);
        check("h_q", q_o[1], 8'h3C);
        check("h_g", g_o[1], 4'b0000);
        drain();

`ifdef BRS_PARITY_EN
        step(1'b1, 2'd0, 1'b0, 9'h0FF);
        for (int n = 0; n < 3; n++) step(1'b0, 2'd0, 1'b0, 9'h0FF);
        check("p_even_perr", perr_o[1], 1'b1);
        drain();
        step(1'b1, 2'd0, 1'b0, 9'h1FF);
        for (int n = 0; n < 3; n++) step(1'b0, 2'd0, 1'b0, 9'h1FF);
        check("p_odd_perr", perr_o[1], 1'b0);
        drain();
`endif

        // randomized traffic with occasional clears
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) do_clear();
            else step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                      $urandom_range(0, 2) == 0, rbus());
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
